// File: rtl/fp_add_pipe.sv
// Three-stage pipelined floating-point adder/subtractor (BF16 by default) with RNE rounding,
// IEEE-style flags, subnormal flush-to-zero and a valid/ready stream interface with full backpressure.
module fp_add_pipe #(
  parameter  int EXP_W     = 8,
  parameter  int MAN_W     = 7,
  localparam int SIZE_DATA = 1 + EXP_W + MAN_W
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [SIZE_DATA-1:0] i_data_a,
  input  logic [SIZE_DATA-1:0] i_data_b,
  input  logic                 i_sub,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [SIZE_DATA-1:0] o_result,
  output logic [3:0]           o_flags
);

  localparam int MW  = MAN_W + 4;          // hidden + fraction + guard + round + sticky
  localparam int SW  = MW + 1;             // adder result including carry-out
  localparam int EW  = EXP_W + 2;          // exponent with headroom and a sign bit
  localparam int LZW = $clog2(MW + 1);
  localparam logic [EXP_W-1:0]     EXP_ONES = '1;
  localparam logic [EXP_W-1:0]     SH_MAX   = EXP_W'(MAN_W + 3);
  localparam logic [SIZE_DATA-1:0] QNAN     = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};

  typedef struct packed {
    logic                 spec;
    logic                 inv;
    logic [SIZE_DATA-1:0] spec_res;
    logic                 sign;
    logic                 zsign;
    logic                 esub;
    logic [EXP_W-1:0]     exp;
    logic [MW-1:0]        mb;
    logic [MW-1:0]        ms;
  } s1_t;

  typedef struct packed {
    logic                 spec;
    logic                 inv;
    logic [SIZE_DATA-1:0] spec_res;
    logic                 sign;
    logic                 zsign;
    logic [EXP_W-1:0]     exp;
    logic [SW-1:0]        sum;
  } s2_t;

  logic                 adv;
  logic                 s1_valid_d, s1_valid_q, s2_valid_d, s2_valid_q, out_valid_d, out_valid_q;
  s1_t                  s1_d, s1_q;
  s2_t                  s2_d, s2_q;
  logic [SIZE_DATA-1:0] out_result_d, out_result_q;
  logic [3:0]           out_flags_d, out_flags_q;

  // The whole pipe advances together; a stalled output freezes every stage.
  assign adv      = ~out_valid_q | i_ready;
  assign o_ready  = adv;
  assign o_valid  = out_valid_q;
  assign o_result = out_result_q;
  assign o_flags  = out_flags_q;

  // Stage 1: unpack, classify, order by magnitude, align the smaller operand.
  logic             sa, sb, a_spec, b_spec, a_nan, b_nan, a_ge_b;
  logic [EXP_W-1:0] ea, eb, diff, shamt;
  logic [MAN_W-1:0] fa, fb;
  logic [MW-1:0]    m_small, mask;

  always_comb begin
    sa     = i_data_a[SIZE_DATA-1];
    ea     = i_data_a[MAN_W +: EXP_W];
    fa     = (ea == '0) ? '0 : i_data_a[MAN_W-1:0];
    sb     = i_data_b[SIZE_DATA-1] ^ i_sub;
    eb     = i_data_b[MAN_W +: EXP_W];
    fb     = (eb == '0) ? '0 : i_data_b[MAN_W-1:0];
    a_spec = (ea == EXP_ONES);
    b_spec = (eb == EXP_ONES);
    a_nan  = a_spec & (fa != '0);
    b_nan  = b_spec & (fb != '0);
    a_ge_b = {ea, fa} >= {eb, fb};

    s1_valid_d    = i_valid;
    s1_d.spec     = a_spec | b_spec;
    s1_d.inv      = 1'b0;
    s1_d.spec_res = QNAN;
    if (a_nan | b_nan)                    s1_d.spec_res = QNAN;
    else if (a_spec & b_spec & (sa != sb)) s1_d.inv     = 1'b1;
    else if (a_spec)                      s1_d.spec_res = {sa, EXP_ONES, {MAN_W{1'b0}}};
    else if (b_spec)                      s1_d.spec_res = {sb, EXP_ONES, {MAN_W{1'b0}}};

    s1_d.esub  = sa ^ sb;
    s1_d.zsign = sa & sb;
    s1_d.sign  = a_ge_b ? sa : sb;
    s1_d.exp   = a_ge_b ? ea : eb;
    diff       = a_ge_b ? (ea - eb) : (eb - ea);
    shamt      = (diff > SH_MAX) ? SH_MAX : diff;
    s1_d.mb    = a_ge_b ? {ea != '0, fa, 3'b000} : {eb != '0, fb, 3'b000};
    m_small    = a_ge_b ? {eb != '0, fb, 3'b000} : {ea != '0, fa, 3'b000};
    mask       = ~({MW{1'b1}} << shamt);
    s1_d.ms    = (m_small >> shamt) | {{(MW-1){1'b0}}, |(m_small & mask)};
  end

  // Stage 2: magnitude add or subtract; big >= small so subtraction never borrows.
  always_comb begin
    s2_valid_d    = s1_valid_q;
    s2_d.spec     = s1_q.spec;
    s2_d.inv      = s1_q.inv;
    s2_d.spec_res = s1_q.spec_res;
    s2_d.sign     = s1_q.sign;
    s2_d.zsign    = s1_q.zsign;
    s2_d.exp      = s1_q.exp;
    s2_d.sum      = s1_q.esub ? ({1'b0, s1_q.mb} - {1'b0, s1_q.ms})
                              : ({1'b0, s1_q.mb} + {1'b0, s1_q.ms});
  end

  // Stage 3: normalise, round to nearest even, pack, raise flags.
  logic [LZW-1:0]   lz;
  logic [MW-1:0]    norm;
  logic [EW-1:0]    exp_n, exp_r;
  logic [MAN_W+1:0] mant_r;
  logic             g, rs, nx, rup;

  // NOTE: every always_comb output gets a value on every path, so no latches are inferred.
  always_comb begin
    lz = '0;
    for (int i = 0; i < MW; i++) if (s2_q.sum[i]) lz = LZW'(MW - 1 - i);
    if (s2_q.sum[SW-1]) begin
      norm  = {s2_q.sum[SW-1:2], s2_q.sum[1] | s2_q.sum[0]};
      exp_n = {2'b00, s2_q.exp} + EW'(1);
    end else begin
      norm  = s2_q.sum[MW-1:0] << lz;
      exp_n = {2'b00, s2_q.exp} - {{(EW-LZW){1'b0}}, lz};
    end
    g      = norm[2];
    rs     = norm[1] | norm[0];
    nx     = g | rs;
    rup    = g & (rs | norm[3]);
    mant_r = {1'b0, norm[MW-1:3]} + {{(MAN_W+1){1'b0}}, rup};
    exp_r  = exp_n + {{(EW-1){1'b0}}, mant_r[MAN_W+1]};

    out_valid_d  = s2_valid_q;
    out_result_d = out_result_q;
    out_flags_d  = out_flags_q;
    if (s2_valid_q) begin
      if (s2_q.spec) begin
        out_result_d = s2_q.spec_res;
        out_flags_d  = {s2_q.inv, 3'b000};
      end else if (s2_q.sum == '0) begin
        out_result_d = {s2_q.zsign, {(SIZE_DATA-1){1'b0}}};
        out_flags_d  = 4'b0000;
      end else if (exp_n[EW-1] || exp_n == '0) begin
        out_result_d = {s2_q.sign, {(SIZE_DATA-1){1'b0}}};
        out_flags_d  = 4'b0011;
      end else if (exp_r >= {2'b00, EXP_ONES}) begin
        out_result_d = {s2_q.sign, EXP_ONES, {MAN_W{1'b0}}};
        out_flags_d  = 4'b0101;
      end else begin
        // A rounding carry leaves mant_r as 10..0, so the stored fraction is already zero.
        out_result_d = {s2_q.sign, exp_r[EXP_W-1:0], mant_r[MAN_W-1:0]};
        out_flags_d  = {3'b000, nx};
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all stages see pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_valid_q   <= 1'b0;
      s1_q         <= '0;
      s2_valid_q   <= 1'b0;
      s2_q         <= '0;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_flags_q  <= '0;
    end else if (adv) begin
      s1_valid_q   <= s1_valid_d;
      s1_q         <= s1_d;
      s2_valid_q   <= s2_valid_d;
      s2_q         <= s2_d;
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
      out_flags_q  <= out_flags_d;
    end
  end

endmodule

// File: tb/tb_fp_add_pipe.sv
// Self-checking bench for fp_add_pipe (BF16): directed vectors, backpressure, reset and a randomized
// stream scored against an exact-arithmetic reference model.
module tb_fp_add_pipe;

  localparam int EXP_W = 8;
  localparam int MAN_W = 7;
  localparam logic [15:0] QNAN = 16'h7FC0;

  localparam logic [15:0] DA [7] = '{16'h3F80, 16'h4040, 16'h3F80, 16'h3F80, 16'h3F81, 16'h7F80, 16'h7F7F};
  localparam logic [15:0] DB [7] = '{16'h3F80, 16'h3F80, 16'hBF80, 16'h3B80, 16'h3B80, 16'hFF80, 16'h7F7F};
  localparam logic        DS [7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam logic [15:0] DR [7] = '{16'h4000, 16'h4000, 16'h0000, 16'h3F80, 16'h3F82, 16'h7FC0, 16'h7F80};
  localparam logic [3:0]  DF [7] = '{4'h0, 4'h0, 4'h0, 4'h1, 4'h1, 4'h8, 4'h5};

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        sub;
    logic [19:0] exp;
  } op_t;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_valid = 1'b0;
  logic        o_ready;
  logic [15:0] i_data_a = '0;
  logic [15:0] i_data_b = '0;
  logic        i_sub = 1'b0;
  logic        o_valid;
  logic        i_ready = 1'b1;
  logic [15:0] o_result;
  logic [3:0]  o_flags;

  int vectors = 0;
  int miscompares = 0;
  op_t sb_q[$];

  always #5 i_clk = ~i_clk;

  fp_add_pipe #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_data_a(i_data_a), .i_data_b(i_data_b), .i_sub(i_sub),
    .o_valid(o_valid), .i_ready(i_ready), .o_result(o_result), .o_flags(o_flags)
  );

  // Exact reference: operands become integers in units of 2^-133, then the sum is rounded RNE.
  function automatic logic [19:0] ref_add(input logic [15:0] a, input logic [15:0] b, input logic sub);
    logic         sa, sb, sr, half, rest, up;
    int           ea, eb, p, er, mant;
    logic [299:0] va, vb, mag, low;
    sa = a[15];
    sb = b[15] ^ sub;
    ea = int'(a[14:7]);
    eb = int'(b[14:7]);
    if ((ea == 255 && a[6:0] != 7'h0) || (eb == 255 && b[6:0] != 7'h0)) return {4'b0000, QNAN};
    if (ea == 255 && eb == 255 && sa != sb) return {4'b1000, QNAN};
    if (ea == 255) return {4'b0000, sa, 15'h7F80};
    if (eb == 255) return {4'b0000, sb, 15'h7F80};
    va = (ea == 0) ? '0 : (300'(128 + int'(a[6:0])) << (ea - 1));
    vb = (eb == 0) ? '0 : (300'(128 + int'(b[6:0])) << (eb - 1));
    if (sa == sb) begin
      mag = va + vb; sr = sa;
    end else if (va >= vb) begin
      mag = va - vb; sr = sa;
    end else begin
      mag = vb - va; sr = sb;
    end
    if (mag == '0) return {4'b0000, sa & sb, 15'h0000};
    p = 0;
    for (int i = 0; i < 300; i++) if (mag[i]) p = i;
    er = p - 6;
    if (er < 1) return {4'b0011, sr, 15'h0000};
    mant = int'(mag >> (p - 7));
    low  = mag & ((300'(1) << (p - 7)) - 300'(1));
    half = (p >= 8) ? mag[p - 8] : 1'b0;
    rest = (p >= 8) ? ((mag & ((300'(1) << (p - 8)) - 300'(1))) != '0) : 1'b0;
    up   = half & (rest | mant[0]);
    mant = mant + int'(up);
    if (mant == 256) begin
      mant = 128; er = er + 1;
    end
    if (er >= 255) return {4'b0101, sr, 15'h7F80};
    return {3'b000, low != '0, sr, er[7:0], mant[6:0]};
  endfunction

  function automatic logic [15:0] rand_op(input logic [15:0] other);
    logic [15:0] r;
    logic [15:0] sp [8];
    int e;
    sp = '{16'h0000, 16'h8000, 16'h7F80, 16'hFF80, 16'h7FC1, 16'h7F7F, 16'h0080, 16'h0005};
    r = 16'($urandom);
    case ($urandom_range(0, 6))
      0, 1: ;
      2, 3, 4: begin
        e = int'(other[14:7]) + int'($urandom_range(0, 6)) - 3;
        if (e < 1) e = 1;
        if (e > 254) e = 254;
        r[14:7] = 8'(e);
      end
      5: r = ($urandom_range(0, 1) == 1) ? other : (other ^ 16'h8000);
      default: r = sp[$urandom_range(0, 7)];
    endcase
    return r;
  endfunction

  // Drives inputs on the falling edge; outputs are then read 1ns later, well clear of the rising edge.
  task automatic drive(input logic v, input logic [15:0] a, input logic [15:0] b,
                       input logic sub, input logic rdy);
    @(negedge i_clk);
    i_valid = v; i_data_a = a; i_data_b = b; i_sub = sub; i_ready = rdy;
    #1;
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0;
    repeat (2) @(negedge i_clk);
    #1;
    vectors++;
    if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_hold: o_valid=%b o_ready=%b, required 0/1", o_valid, o_ready);
    end
    @(negedge i_clk);
    i_rst_n = 1'b1;
    drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
    vectors++;
    if (o_valid !== 1'b0 || o_ready !== 1'b1 || o_result !== 16'h0 || o_flags !== 4'h0) begin
      miscompares++;
      $display("FAIL reset_state: valid=%b ready=%b result=%h flags=%h, required 0/1/0000/0",
               o_valid, o_ready, o_result, o_flags);
    end
  endtask

  task automatic test_directed();
    for (int k = 0; k < 7; k++) begin
      drive(1'b1, DA[k], DB[k], DS[k], 1'b1);
      vectors++;
      if (o_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL directed_accept[%0d]: o_ready=%b, required 1", k, o_ready);
      end
      for (int n = 1; n <= 3; n++) begin
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
        vectors++;
        if (n < 3) begin
          if (o_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL directed_latency[%0d]: o_valid=1 after %0d cycles, required 0", k, n);
          end
        end else if (o_valid !== 1'b1 || o_result !== DR[k] || o_flags !== DF[k]) begin
          miscompares++;
          $display("FAIL directed[%0d] %h%s%h: valid=%b result=%h flags=%h, required 1/%h/%h",
                   k, DA[k], DS[k] ? "-" : "+", DB[k], o_valid, o_result, o_flags, DR[k], DF[k]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int  sent = 0;
    int  got = 0;
    logic rdy;
    logic [15:0] a, b;
    op_t  op;
    sb_q.delete();
    for (int c = 0; c < 60 && (sent < 8 || sb_q.size() != 0); c++) begin
      rdy = !(c >= 3 && c < 8);
      a = rand_op(16'h3F80);
      b = rand_op(a);
      drive(sent < 8, a, b, c[0], rdy);
      vectors++;
      if (o_ready !== (~o_valid | rdy)) begin
        miscompares++;
        $display("FAIL bp_ready c=%0d: o_ready=%b, required %b", c, o_ready, ~o_valid | rdy);
      end
      if (o_valid && rdy) begin
        vectors++;
        got++;
        if (sb_q.size() == 0) begin
          miscompares++;
          $display("FAIL bp_extra: result %h with nothing outstanding, required no output", o_result);
        end else begin
          op = sb_q.pop_front();
          if ({o_flags, o_result} !== op.exp) begin
            miscompares++;
            $display("FAIL bp_result %h%s%h: got %h/%h, required %h/%h", op.a, op.sub ? "-" : "+",
                     op.b, o_result, o_flags, op.exp[15:0], op.exp[19:16]);
          end
        end
      end
      if (sent < 8 && o_ready) begin
        sb_q.push_back('{a: a, b: b, sub: c[0], exp: ref_add(a, b, c[0])});
        sent++;
      end
    end
    vectors++;
    if (got != 8 || sb_q.size() != 0) begin
      miscompares++;
      $display("FAIL bp_count: received %0d with %0d outstanding, required 8 and 0", got, sb_q.size());
    end
  endtask

  task automatic test_random();
    logic v, rdy, sub;
    logic [15:0] a, b;
    op_t op;
    sb_q.delete();
    for (int c = 0; c < 2000 + 40 && (c < 2000 || sb_q.size() != 0); c++) begin
      v   = (c < 2000) && ($urandom_range(0, 9) < 7);
      rdy = (c >= 2000) || ($urandom_range(0, 3) != 0);
      a   = rand_op(16'($urandom));
      b   = rand_op(a);
      sub = 1'($urandom_range(0, 1));
      drive(v, a, b, sub, rdy);
      vectors++;
      if (o_ready !== (~o_valid | rdy)) begin
        miscompares++;
        $display("FAIL rand_ready c=%0d: o_ready=%b, required %b", c, o_ready, ~o_valid | rdy);
      end
      if (o_valid && rdy) begin
        vectors++;
        if (sb_q.size() == 0) begin
          miscompares++;
          $display("FAIL rand_extra: result %h with nothing outstanding, required no output", o_result);
        end else begin
          op = sb_q.pop_front();
          if ({o_flags, o_result} !== op.exp) begin
            miscompares++;
            $display("FAIL rand_result %h%s%h: got %h/%h, required %h/%h", op.a, op.sub ? "-" : "+",
                     op.b, o_result, o_flags, op.exp[15:0], op.exp[19:16]);
          end
        end
      end
      if (v && o_ready) sb_q.push_back('{a: a, b: b, sub: sub, exp: ref_add(a, b, sub)});
    end
    vectors++;
    if (sb_q.size() != 0) begin
      miscompares++;
      $display("FAIL rand_drain: %0d results outstanding, required 0", sb_q.size());
    end
  endtask

  task automatic test_reset_midflight();
    for (int k = 0; k < 3; k++) drive(1'b1, 16'h3F80, 16'h4000 + 16'(k), 1'b0, 1'b1);
    drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
    vectors++;
    if (o_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL midflight_busy: o_valid=%b, required 1", o_valid);
    end
    #2 i_rst_n = 1'b0;
    #1;
    vectors++;
    if (o_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL midflight_reset: o_valid=%b right after reset, required 0", o_valid);
    end
    repeat (2) @(negedge i_clk);
    i_rst_n = 1'b1;
    for (int n = 0; n < 6; n++) begin
      drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
      vectors++;
      if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL midflight_stale[%0d]: valid=%b ready=%b, required 0/1", n, o_valid, o_ready);
      end
    end
    drive(1'b1, 16'h4040, 16'h3F80, 1'b0, 1'b1);
    repeat (3) drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
    vectors++;
    if (o_valid !== 1'b1 || o_result !== 16'h4080 || o_flags !== 4'h0) begin
      miscompares++;
      $display("FAIL midflight_resume: valid=%b result=%h flags=%h, required 1/4080/0",
               o_valid, o_result, o_flags);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_random();
    test_reset_midflight();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "time limit reached");
  end

endmodule
